// File: rtl/seq_mult_shift_add_if.sv
// Operand/result handshake bundle for seq_mult_shift_add.
// master drives start/a/b; slave returns busy/done/product.
interface seq_mult_shift_add_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add multiplier, fixed WIDTH-cycle iteration, start/busy/done handshake.
// Define MLT_SIGNED_EN for two's-complement operands (adds one SGN cycle of latency).
module seq_mult_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    seq_mult_shift_add_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int PW    = 2 * WIDTH;

`ifdef MLT_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, SGN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t            state;
    logic [PW-1:0]     a_q;
    logic [WIDTH-1:0]  b_q;
    logic [PW-1:0]     p_q;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     prod_q;

    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic [PW-1:0]     p_add;
    logic              last;
    logic              zero_op;

`ifdef MLT_SIGNED_EN
    logic              neg_q;
    logic [PW-1:0]     p_sgn;

    // Magnitude of the most-negative value still fits unsigned in WIDTH bits.
    always_comb begin
        a_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_in = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end

    always_comb p_sgn = neg_q ? -p_q : p_q;
`else
    always_comb begin
        a_in = bus.a;
        b_in = bus.b;
    end
`endif

    always_comb begin
        p_add   = b_q[0] ? (p_q + a_q) : p_q;
        last    = (cnt == CNT_W'(WIDTH - 1));
        zero_op = (a_in == '0) || (b_in == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            prod_q <= '0;
`ifdef MLT_SIGNED_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= {{WIDTH{1'b0}}, a_in};
                        b_q    <= b_in;
                        p_q    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef MLT_SIGNED_EN
                        neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        state  <= zero_op ? SGN : CALC;
`else
                        if (zero_op) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            prod_q <= '0;
                        end else begin
                            state  <= CALC;
                        end
`endif
                    end
                end
                CALC: begin
                    p_q <= p_add;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
`ifdef MLT_SIGNED_EN
                        state  <= SGN;
`else
                        // Result register loads on DONE entry so it is valid alongside done.
                        state  <= DONE;
                        done_q <= 1'b1;
                        prod_q <= p_add;
`endif
                    end
                end
`ifdef MLT_SIGNED_EN
                SGN: begin
                    p_q    <= p_sgn;
                    prod_q <= p_sgn;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
`endif
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;
endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Parametrised sequential shift-and-add unsigned multiplier with its own datapath and control FSM.
- Generalises the repeated-addition multiplier controller:
  - fixed latency independent of operand value (WIDTH iterations, not B iterations);
  - start/busy/done handshake;
  - zero-operand shortcut;
  - optional signed mode.
- Sits between an operand source (register file or bus slave) and a result consumer sampling on done.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..32); product width is 2*WIDTH.
- CNT_W, derived localparam = clog2(WIDTH)+1, iteration counter width; not user-overridable.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high from the cycle after accepted start until the cycle done is high, inclusive.
- done  output  1  single-cycle pulse; product valid.
- product  output  2*WIDTH  result register; holds until next accepted start.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal A, B, P and counter cleared.
  - Reset mid-operation aborts immediately: no done pulse, product=0.
- States: IDLE, CALC, DONE (plus SGN when MLT_SIGNED_EN is defined). Encoding is free.
- IDLE:
  - busy=0, done=0.
  - On start=1 at edge k: A<=a zero-extended to 2*WIDTH, B<=b, P<=0, cnt<=0.
  - If a==0 or b==0: go directly to DONE (zero shortcut) with P=0. Otherwise go to CALC.
- CALC, once per cycle:
  - If B[0]==1: P<=P+A.
  - A<=A<<1; B<=B>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 (last iteration), go to DONE.
  - Additions are 2*WIDTH wide. No overflow is possible; the carry out of bit 2*WIDTH-1 is discarded by construction.
- DONE:
  - product<=P registered on entry, so product is valid in the same cycle done is high.
  - done=1 for exactly one cycle; busy=1; next state IDLE.
- Latency, start accepted at edge k:
  - normal: done high in cycle k+WIDTH+1 (WIDTH CALC cycles + DONE);
  - zero shortcut: done high in cycle k+1.
- Handshake:
  - start while busy or in DONE is ignored: no queueing, no effect on the current operation.
  - start held high continuously is re-accepted in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).
  - a and b may change freely after the accepting edge.
- product is stable between done pulses. It is not cleared on a new start; it is overwritten only in DONE.

Optional Feature:
- Macro: MLT_SIGNED_EN.
- Defined:
  - a and b are two's complement.
  - At acceptance, magnitudes |a| and |b| are loaded and neg=a[MSB]^b[MSB] is stored.
  - After CALC (or after the zero shortcut), the FSM passes through SGN for one cycle: P<=neg ? -P : P, then DONE.
  - Latency increases by 1 cycle: normal k+WIDTH+2, shortcut k+2.
  - Most-negative operand (e.g. -128 for WIDTH=8): its magnitude 2^(WIDTH-1) is held in the unsigned WIDTH-bit register and gives the correct result (-128*-128=16384).
- Undefined: purely unsigned, no SGN state, no neg register.

Test Plan:
1. WIDTH=8, a=13, b=11, start pulse at edge k -> busy=1 from k+1; done=1 only in cycle k+9; product=143 (0x008F), held until the next start.
2. a=255, b=255 -> product=65025 (0xFE01) after 9 cycles; no overflow; done is a single pulse.
3. a=0, b=200 -> done in cycle k+1, product=0. Also a=77, b=0 -> product=0, same latency.
4. Start a=6, b=7. During CALC, pulse start with a=2, b=2 -> ignored; product=42. Then start held high -> second operation begins the cycle after done, again with 9-cycle latency.
5. Start a=9, b=9; drive resetn low asynchronously (mid-cycle) at CALC iteration 4 -> busy, done and product go to 0 immediately, no done pulse. After release, a=3, b=5 gives product=15.
6. MLT_SIGNED_EN defined:
   - a=-3 (0xFD), b=5 -> product=0xFFF1 (-15), done at k+10;
   - a=-128, b=-128 -> product=0x4000.
